// File: rtl/wb_rom_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone ROM slave between two read masters.
// Grants are held per bus cycle, and an outstanding-strobe count routes every ack back to its master.
module wb_rom_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic [AW-1:0] m0_adr,
  output logic [DW-1:0] m0_dat,
  output logic          m0_ack,
  output logic          m0_stall,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic [AW-1:0] m1_adr,
  output logic [DW-1:0] m1_dat,
  output logic          m1_ack,
  output logic          m1_stall,
  output logic          s_cyc,
  output logic          s_stb,
  output logic [AW-1:0] s_adr,
  input  logic [DW-1:0] s_dat,
  input  logic          s_ack,
  input  logic          s_stall
);

  localparam int            CW     = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUT);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic          last_r, last_s;
  logic [CW-1:0] out_r, out_s;
  logic          gnt0_s, gnt1_s, sel_cyc_s, sel_stb_s;
  logic          busy_s, full_s, accept_s, ack_ok_s;

  // Bus steering: outputs follow the registered grant, so reset clears them without a clock.
  always_comb begin
    gnt0_s = (state_r == G0);
    gnt1_s = (state_r == G1);
    busy_s = (out_r != ZERO_C);
    full_s = (out_r >= MAX_C);
    if (gnt0_s) begin
      sel_cyc_s = m0_cyc;
      sel_stb_s = m0_stb;
      s_adr     = m0_adr;
    end else if (gnt1_s) begin
      sel_cyc_s = m1_cyc;
      sel_stb_s = m1_stb;
      s_adr     = m1_adr;
    end else begin
      sel_cyc_s = 1'b0;
      sel_stb_s = 1'b0;
      s_adr     = {AW{1'b0}};
    end
    s_stb    = sel_cyc_s & sel_stb_s & ~full_s;
    // An aborted master still owns the bus until its in-flight acks drain.
    s_cyc    = (gnt0_s | gnt1_s) & (sel_cyc_s | busy_s);
    accept_s = s_stb & ~s_stall;
    ack_ok_s = s_ack & busy_s;
    m0_stall = gnt0_s ? (s_stall | full_s) : 1'b1;
    m1_stall = gnt1_s ? (s_stall | full_s) : 1'b1;
    m0_ack   = gnt0_s & ack_ok_s & m0_cyc;
    m1_ack   = gnt1_s & ack_ok_s & m1_cyc;
    m0_dat   = gnt0_s ? s_dat : {DW{1'b0}};
    m1_dat   = gnt1_s ? s_dat : {DW{1'b0}};
  end

  // Outstanding-strobe count; an ack with nothing outstanding is ignored.
  always_comb begin
    case ({accept_s, ack_ok_s})
      2'b10:   out_s = out_r + ONE_C;
      2'b01:   out_s = out_r - ONE_C;
      default: out_s = out_r;
    endcase
  end

  // Grant selection: round-robin on ties, release only once cyc is low and the count is drained.
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    case (state_r)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          state_s = last_r ? G0 : G1;
        end else if (m0_cyc) begin
          state_s = G0;
        end else if (m1_cyc) begin
          state_s = G1;
        end else begin
          state_s = IDLE;
        end
      end
      G0: begin
        if (!m0_cyc && !busy_s) begin
          last_s  = 1'b0;
          state_s = m1_cyc ? G1 : IDLE;
        end else begin
          state_s = G0;
        end
      end
      G1: begin
        if (!m1_cyc && !busy_s) begin
          last_s  = 1'b1;
          state_s = m0_cyc ? G0 : IDLE;
        end else begin
          state_s = G1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, round-robin pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      out_r   <= ZERO_C;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
      out_r   <= out_s;
    end
  end

endmodule

// File: doc/wb_rom_arbiter.md
Name: wb_rom_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter using classic pipelined cycles.
- Shares the program ROM between the J1 instruction-fetch port (m0) and a data/debug read port (m1).
- Grants are round-robin and held for a whole bus cycle (cyc).
- Tracks outstanding strobes so that every ack is routed to the master that issued it, and the slave is never handed over mid-burst.

Parameters:
- AW, 16, address width of masters and slave.
- DW, 16, data width.
- MAX_OUT, 4, maximum accepted-but-unacked strobes per grant (1..15).

Ports:
- clk  in  1  bus clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_cyc  in  1  master 0 cycle.
- m0_stb  in  1  master 0 strobe.
- m0_adr  in  AW  master 0 address.
- m0_dat  out  DW  read data to master 0.
- m0_ack  out  1  ack to master 0.
- m0_stall  out  1  stall to master 0.
- m1_cyc, m1_stb, m1_adr, m1_dat, m1_ack, m1_stall: same directions, widths and meanings for master 1.
- s_cyc  out  1  slave cycle.
- s_stb  out  1  slave strobe.
- s_adr  out  AW  slave address.
- s_dat  in  DW  slave read data.
- s_ack  in  1  slave ack.
- s_stall  in  1  slave stall.

Behaviour:
- Reset (async on rst_n low, released synchronously to clk):
  - state=IDLE, last=1 (so m0 wins first tie), outstanding=0.
  - All outputs are 0, except m0_stall=m1_stall=1.
- States: IDLE, G0, G1 (one-hot or binary; registered).
- IDLE:
  - No grant. Both masters stall; s_cyc=0, s_stb=0.
  - If only mN_cyc=1, go to GN.
  - If both are 1, go to G(1-last), i.e. round-robin.
  - Grant takes effect the cycle after cyc is sampled. A master's first strobe can be accepted no earlier than 1 cycle after it raises cyc.
- GN (granted master N):
  - s_adr=mN_adr.
  - s_stb = mN_cyc & mN_stb & (outstanding<MAX_OUT).
  - s_cyc = mN_cyc | (outstanding!=0).
  - mN_stall = s_stall | (outstanding==MAX_OUT).
  - The other master's stall is 1, its ack is 0, and its dat is 0.
- Transfer accepted: s_stb & ~s_stall.
- outstanding counter:
  - +1 on accept, -1 on s_ack. Both in the same cycle: unchanged.
  - Width is clog2(MAX_OUT+1).
  - s_ack while outstanding==0 is ignored; the counter saturates at 0 and no master ack is generated.
- Ack routing:
  - mN_ack = s_ack & (outstanding!=0) & mN_cyc. Combinational, zero added latency.
  - mN_dat = s_dat when GN, else 0.
- Release: GN returns when mN_cyc=0 and outstanding==0, sampled at clk.
  - Set last=N.
  - If the other master's cyc=1 in that same cycle, go directly to its grant (no IDLE bubble); otherwise go to IDLE.
  - If mN_cyc is still 1, stay in GN; no preemption.
- Abort (mN_cyc drops while outstanding>0):
  - s_cyc stays 1 until the counter drains. The drained acks are consumed and not forwarded, since mN_cyc=0.
  - The grant is held until the drain completes. mN re-raising cyc during the drain keeps the grant; its new strobes obey the MAX_OUT limit.
- Slave stall: while s_stall=1, s_stb holds its value with the address stable (the master holds, per Wishbone). Counter unchanged.
- End-to-end timing: with a 0-waitcycle ROM, stb accepted at cycle T gives ack and data at T+1. Back-to-back strobes give one word per cycle.
- Reset asserted mid-transfer: everything returns immediately to reset values. Slave acks arriving after rst_n deasserts, with outstanding=0, are dropped.

Test Plan:
1. Single master, 0-waitcycle ROM:
   - Stimulus: m0 raises cyc at cycle 0 and strobes adr 0x0000..0x0003 back-to-back.
   - Required: m0_stall=1 at cycle 0 only; acks at cycles 2..5 with ROM[0..3]; returns to IDLE the cycle after cyc drops.
2. Contention:
   - Stimulus: m0 and m1 raise cyc in the same cycle from reset.
   - Required: m0 is granted first; m1 stays stalled with ack=0 throughout. On m0 release, m1 is granted with no IDLE cycle. Next tie goes to m0 (last=1).
3. Outstanding limit:
   - Stimulus: MAX_OUT=2, ROM waitcycles=1, m0 strobes continuously.
   - Required: outstanding never exceeds 2; m0_stall=1 while it equals 2; every accepted strobe gets exactly one ack.
4. Abort:
   - Stimulus: m1 drops cyc with 2 outstanding; m0 is requesting.
   - Required: s_cyc stays 1 for 2 more acks; m1_ack=0 and m0_ack=0 for those acks; m0 is granted the cycle after outstanding reaches 0.
5. Spurious ack:
   - Stimulus: s_ack=1 in IDLE.
   - Required: counter stays 0; m0_ack=m1_ack=0.
6. Async reset:
   - Stimulus: rst_n low mid-burst, between clock edges.
   - Required: outputs go to reset values without waiting for a clock edge; normal arbitration resumes after release.
